// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate enable, h/v counters and registered sync/DE/strobes.
// Define VGA_TEST_PATTERN_EN to add registered r/g/b colour-bar outputs aligned to de.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_en,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [3:0]    r,
  output logic [3:0]    g,
  output logic [3:0]    b
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG    = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          pix_q, pix_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic          step;
  logic          h_wrap;

  // Flags are decoded from the next-count values so they land in the same edge as the counts.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    step   = en && (div_q == DIV_LAST);
    h_wrap = (h_q == H_LAST);
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    de_d   = de_q;
    pix_d  = step;
    ls_d   = 1'b0;
    fs_d   = 1'b0;

    if (en) begin
      div_d = step ? '0 : div_q + 1'b1;
    end

    if (step) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
      hs_d = ((h_d >= HS_BEG) && (h_d < HS_END)) ? HS_POL : !HS_POL;
      vs_d = ((v_d >= VS_BEG) && (v_d < VS_END)) ? VS_POL : !VS_POL;
      de_d = (h_d < H_ACT_END) && (v_d < V_ACT_END);
      ls_d = (h_d == '0);
      fs_d = (h_d == '0) && (v_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      div_q <= '0;
      h_q   <= H_LAST;
      v_q   <= V_LAST;
      pix_q <= 1'b0;
      hs_q  <= !HS_POL;
      vs_q  <= !VS_POL;
      de_q  <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      pix_q <= pix_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign pix_en      = pix_q;
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_idx;
  logic [2:0]  code;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_d >= CW'(k * BAR_W)) bar_idx = 3'(k);
    end
    code  = ~bar_idx;  // 7 - k for a 3-bit index
    rgb_d = rgb_q;
    if (step) begin
      rgb_d = de_d ? {{4{code[2]}}, {4{code[1]}}, {4{code[0]}}} : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= rgb_d;
  end

  assign r = rgb_q[11:8];
  assign g = rgb_q[7:4];
  assign b = rgb_q[3:0];
`endif

endmodule
